delay_config_sequencer: RTL and testbench
=========================================

# delay_config_sequencer

Sequencer that owns the per-channel delay settings feeding the coincidence detector's delay generator. Host-side writes are staged in shadow registers and applied to the live `Delays` bus atomically, only after all input channels have been quiet long enough for the delay lines to drain. This prevents a setting change from corrupting pulses already in flight. An optional sweep mode steps one channel's delay through its full range for calibration.

## Interface
- `NCHAN`, 4: number of channels.
- `NBITS`, 4: delay setting width; maximum delay is 2^NBITS-1.
- `DRAIN`, 16: number of consecutive quiet cycles required before apply; must be ≥1.
- `DWELL`, 1024: cycles held at each sweep step; must be ≥1.
- `Clk`  in  1  clock; single clock domain.
- `Rst`  in  1  synchronous, active-high reset.
- `Channels`  in  NCHAN  live channel inputs, monitored for activity.
- `WrValid`  in  1  staging-write request.
- `WrReady`  out  1  staging write accepted when high.
- `WrChan`  in  $clog2(NCHAN)  target channel index.
- `WrDelay`  in  NBITS  new delay value.
- `Commit`  in  1  request to apply the staged settings.
- `Delays`  out  NBITS x [NCHAN-1:0] unpacked  live settings driven to the delay generator.
- `Busy`  out  1  high while a drain, apply or sweep is in progress.
- `Applied`  out  1  one-cycle pulse when `Delays` has changed.
- `SweepStart`, `SweepChan` (in, 1 and $clog2(NCHAN)); `SweepStep`, `SweepDone` (out, 1 each): present only with the sweep macro.

## Operation
- Reset values:
  - all shadow registers and `Delays` = 0.
  - `Busy` = 0, `Applied` = 0, `SweepStep` = 0, `SweepDone` = 0.
  - `WrReady` = 1; state = IDLE.
- States: IDLE, DRAIN, DWELL (DWELL exists only with the sweep macro).
- `WrReady` = (state == IDLE).
- Staging writes:
  - A write occurs when `WrValid` and `WrReady` are both high; it sets shadow[WrChan] = WrDelay.
  - If WrChan ≥ NCHAN, the write is accepted and discarded.
- IDLE → DRAIN:
  - Taken when `Commit` is high.
  - The drain counter loads DRAIN-1.
  - If a write and `Commit` arrive in the same cycle, the write is staged first and included in the commit.
- DRAIN:
  - Any `Channels` bit high: reload the counter to DRAIN-1.
  - All `Channels` bits low and counter ≠ 0: decrement.
  - All `Channels` bits low and counter == 0: register `Delays` ← shadow, pulse `Applied`, go to IDLE (or DWELL when sweeping).
- A commit with nothing staged still performs the full drain and apply sequence.
- `Commit` outside IDLE is ignored; commits are not queued.
- `Delays` never changes outside an apply, so every channel switches in the same cycle.
- Reset asserted in any state returns the block to its reset values; any in-flight commit or sweep is lost.

## Timing
- Write handshake: accepted at edge k → shadow updated at k+1. Shadow is not observable; it appears on `Delays` only after commit.
- Commit latency with `Channels` quiet (`Commit` sampled at edge k):
  - `Busy` = 1 from k+1.
  - `Delays` takes the new value at k+DRAIN+1.
  - `Applied` = 1 for that single cycle.
  - `Busy` = 0 and `WrReady` = 1 in the same cycle.
- Activity extends the drain: a `Channels` pulse at cycle m delays the apply to no earlier than m+DRAIN+1.

## Configuration
- `DLYCFG_SWEEP_EN` defined:
  - `SweepStart` in IDLE saves the current Delays[SweepChan], sets shadow[SweepChan] = 0, and enters DRAIN.
  - After each apply, the block holds DWELL for DWELL cycles, then pulses `SweepStep`.
  - It then increments shadow[SweepChan] and drains/applies again.
  - After the dwell at 2^NBITS-1, it restores the saved value through a final drain/apply, pulses `SweepDone` together with that `Applied`, and returns to IDLE.
  - `Busy` stays high for the whole sweep.
  - `Commit` and writes are blocked during the sweep.
  - If `SweepStart` and `Commit` arrive together, `SweepStart` wins.
- `DLYCFG_SWEEP_EN` undefined: the sweep ports, the DWELL state and the save register are absent; behaviour is otherwise identical.

## Structure
- Package `dlycfg_pkg`:
  - state enum `dlycfg_state_e`.
  - localparam `CHW = $clog2(NCHAN)` helper.
  - delay setting typedef `dly_t` (NBITS-wide logic).
- One sub-module, `quiet_timer`: a loadable down-counter with a restart input (the `Channels` OR-reduce) and a `Done` output. It is reused for both the drain and dwell counts.

## Test plan
- Reset: hold `Rst` 2 cycles → all `Delays` = 0, `WrReady` = 1, `Busy` = 0, `Applied` = 0.
- Basic commit: write ch2=5, `Commit` at edge k with `Channels` = 0 → Delays[2] = 5 and `Applied` high exactly at k+17; Delays[2] = 0 before that.
- Activity extension: same as basic commit, but Channels[0] pulses at k+8 → apply at k+25; a second pulse at k+20 → apply at k+37.
- Blocked writes: write ch1=3 while `Busy` → `WrReady` = 0; after the apply, Delays[1] is unchanged. A write with WrChan = NCHAN is discarded.
- Same-cycle write and commit, then reset: write ch3=9 with `Commit` in the same cycle → Delays[3] = 9 at k+17. A second commit with `Rst` asserted at k+5 → state IDLE and all `Delays` = 0.
- Sweep (`DLYCFG_SWEEP_EN`, DWELL = 4): Delays[1] = 7, start sweep on ch1:
  - Delays[1] steps 0..15, with 16 `SweepStep` pulses spaced DWELL+DRAIN+1 cycles apart.
  - Delays[1] returns to 7 with `SweepDone` pulsed once.

Source files
------------

// File: rtl/dlycfg_pkg.sv
// Shared types and helpers for the delay configuration sequencer.
// DWELL state exists only when DLYCFG_SWEEP_EN is defined.
package dlycfg_pkg;

    localparam int DLY_NCHAN = 4;
    localparam int DLY_NBITS = 4;
    localparam int CHW       = $clog2(DLY_NCHAN);

    typedef logic [DLY_NBITS-1:0] dly_t;

`ifdef DLYCFG_SWEEP_EN
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DWELL} dlycfg_state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_DRAIN} dlycfg_state_e;
`endif

    // Counter width able to hold the larger of the two reload values.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/delay_config_sequencer_quiet_timer.sv
// Loadable down-counter; restart reloads it, done is high while the count sits at zero.
// One cycle from load/restart to the new count; no backpressure.
module quiet_timer #(
    parameter int CNTW = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CNTW-1:0] load_val_i,
    input  logic            restart_i,
    output logic            done_o
);

    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || restart_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/delay_config_sequencer.sv
// Stages per-channel delays and applies them atomically after DRAIN quiet cycles; writes stall while busy.
// Optional calibration sweep of one channel under DLYCFG_SWEEP_EN.
module delay_config_sequencer
    import dlycfg_pkg::*;
#(
    parameter int NCHAN = DLY_NCHAN,
    parameter int NBITS = DLY_NBITS,
    parameter int DRAIN = 16,
    parameter int DWELL = 1024,
    localparam int CW = (NCHAN == DLY_NCHAN) ? CHW : ((NCHAN > 1) ? $clog2(NCHAN) : 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [NCHAN-1:0] Channels,
    input  logic             WrValid,
    output logic             WrReady,
    input  logic [CW-1:0]    WrChan,
    input  logic [NBITS-1:0] WrDelay,
    input  logic             Commit,
    output logic [NBITS-1:0] Delays [NCHAN-1:0],
    output logic             Busy,
    output logic             Applied
`ifdef DLYCFG_SWEEP_EN
    ,
    input  logic             SweepStart,
    input  logic [CW-1:0]    SweepChan,
    output logic             SweepStep,
    output logic             SweepDone
`endif
);

    localparam int         TW      = cnt_width(DRAIN, DWELL);
    localparam logic [CW:0] NCHAN_W = (CW + 1)'(NCHAN);

    dlycfg_state_e    state_q, state_d;
    logic [NBITS-1:0] shadow_q [NCHAN-1:0];
    logic [NBITS-1:0] shadow_d [NCHAN-1:0];
    logic [NBITS-1:0] delays_q [NCHAN-1:0];
    logic [NBITS-1:0] delays_d [NCHAN-1:0];
    logic             applied_q, applied_d;
    logic             active, restart, tmr_load, tmr_done;
    logic [TW-1:0]    tmr_val;
`ifdef DLYCFG_SWEEP_EN
    logic             sweep_q, sweep_d, restore_q, restore_d;
    logic             step_q, step_d, done_q, done_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic [NBITS-1:0] saved_q, saved_d;
`endif

    assign active  = |Channels;
    assign restart = (state_q == S_DRAIN) && active;

    quiet_timer #(.CNTW(TW)) u_timer (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .restart_i  (restart),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        delays_d  = delays_q;
        applied_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = TW'(DRAIN - 1);
`ifdef DLYCFG_SWEEP_EN
        sweep_d   = sweep_q;
        restore_d = restore_q;
        step_d    = 1'b0;
        done_d    = 1'b0;
        chan_d    = chan_q;
        saved_d   = saved_q;
`endif
        // Out-of-range channel writes complete the handshake but change nothing.
        if (WrValid && (state_q == S_IDLE) && ({1'b0, WrChan} < NCHAN_W)) begin
            shadow_d[WrChan] = WrDelay;
        end
        case (state_q)
            S_IDLE: begin
`ifdef DLYCFG_SWEEP_EN
                if (SweepStart && ({1'b0, SweepChan} < NCHAN_W)) begin
                    saved_d             = delays_q[SweepChan];
                    chan_d              = SweepChan;
                    shadow_d[SweepChan] = '0;
                    sweep_d             = 1'b1;
                    restore_d           = 1'b0;
                    tmr_load            = 1'b1;
                    state_d             = S_DRAIN;
                end else
`endif
                if (Commit) begin
                    tmr_load = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!active && tmr_done) begin
                    delays_d  = shadow_q;
                    applied_d = 1'b1;
                    state_d   = S_IDLE;
`ifdef DLYCFG_SWEEP_EN
                    if (sweep_q) begin
                        if (restore_q) begin
                            done_d    = 1'b1;
                            sweep_d   = 1'b0;
                            restore_d = 1'b0;
                        end else begin
                            state_d  = S_DWELL;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(DWELL);
                        end
                    end
`endif
                end
            end
`ifdef DLYCFG_SWEEP_EN
            S_DWELL: begin
                if (tmr_done) begin
                    step_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = S_DRAIN;
                    // The last step hands back the setting that was live before the sweep.
                    if (shadow_q[chan_q] == '1) begin
                        shadow_d[chan_q] = saved_q;
                        restore_d        = 1'b1;
                    end else begin
                        shadow_d[chan_q] = shadow_q[chan_q] + NBITS'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            shadow_q  <= '{default: '0};
            delays_q  <= '{default: '0};
            applied_q <= 1'b0;
`ifdef DLYCFG_SWEEP_EN
            sweep_q   <= 1'b0;
            restore_q <= 1'b0;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
            chan_q    <= '0;
            saved_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            delays_q  <= delays_d;
            applied_q <= applied_d;
`ifdef DLYCFG_SWEEP_EN
            sweep_q   <= sweep_d;
            restore_q <= restore_d;
            step_q    <= step_d;
            done_q    <= done_d;
            chan_q    <= chan_d;
            saved_q   <= saved_d;
`endif
        end
    end

    assign Delays  = delays_q;
    assign Applied = applied_q;
    assign Busy    = (state_q != S_IDLE);
    assign WrReady = (state_q == S_IDLE);
`ifdef DLYCFG_SWEEP_EN
    assign SweepStep = step_q;
    assign SweepDone = done_q;
`endif

endmodule

// File: tb/tb_delay_config_sequencer.sv
// Scoreboarded bench for delay_config_sequencer; sweep section runs when DLYCFG_SWEEP_EN is defined.
// Cycle labels: the cycle following clock edge e is cycle e+1, matching the commit-latency numbering.
module tb_delay_config_sequencer;

    localparam int NCHAN = 4;
    localparam int NBITS = 4;
    localparam int DRAIN = 16;
    localparam int DWELL = 4;
    localparam int STEP_P = DRAIN + DWELL + 1;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [NCHAN-1:0] Channels;
    logic             WrValid, WrReady, Commit, Busy, Applied;
    logic [1:0]       WrChan;
    logic [NBITS-1:0] WrDelay;
    logic [NBITS-1:0] Delays [NCHAN-1:0];
`ifdef DLYCFG_SWEEP_EN
    logic             SweepStart, SweepStep, SweepDone;
    logic [1:0]       SweepChan;
`endif

    delay_config_sequencer #(
        .NCHAN(NCHAN), .NBITS(NBITS), .DRAIN(DRAIN), .DWELL(DWELL)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Channels (Channels),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrChan   (WrChan),
        .WrDelay  (WrDelay),
        .Commit   (Commit),
        .Delays   (Delays),
        .Busy     (Busy),
        .Applied  (Applied)
`ifdef DLYCFG_SWEEP_EN
        ,
        .SweepStart (SweepStart),
        .SweepChan  (SweepChan),
        .SweepStep  (SweepStep),
        .SweepDone  (SweepDone)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int dly;
        bit done;
    } exp_t;

    exp_t             exp_q[$];
    int               step_q[$];
    exp_t             mon_e;
    logic [NBITS-1:0] model [NCHAN-1:0];
    int               checks = 0;
    int               failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pack_dly(input logic [NBITS-1:0] d [NCHAN-1:0]);
        int r = 0;
        for (int i = 0; i < NCHAN; i++) r = r | (int'(d[i]) << (NBITS * i));
        return r;
    endfunction

    task automatic push_apply(input int at, input bit done);
        exp_t e;
        e.at   = at;
        e.dly  = pack_dly(model);
        e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        while (Busy && n < limit) begin
            tick(1);
            n++;
        end
        chk({nm, "_idle"}, int'(Busy), 0);
    endtask

    // Monitor: every Applied pulse must match the next queued expectation.
    always @(negedge Clk) begin
        if (Applied) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_applied", cyc + 1, -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("apply_cycle", cyc + 1, mon_e.at);
                chk("apply_delays", pack_dly(Delays), mon_e.dly);
`ifdef DLYCFG_SWEEP_EN
                chk("sweep_done_flag", int'(SweepDone), int'(mon_e.done));
`endif
            end
        end
`ifdef DLYCFG_SWEEP_EN
        if (SweepStep) begin
            if (step_q.size() == 0) chk("unexpected_step", cyc + 1, -1);
            else chk("step_cycle", cyc + 1, step_q.pop_front());
        end
        if (SweepDone && !Applied) chk("done_without_apply", cyc + 1, -1);
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        Rst = 1'b1; Channels = '0; WrValid = 1'b0; WrChan = '0; WrDelay = '0; Commit = 1'b0;
`ifdef DLYCFG_SWEEP_EN
        SweepStart = 1'b0; SweepChan = '0;
`endif
        for (int i = 0; i < NCHAN; i++) model[i] = '0;

        // Reset held for two edges.
        tick(2);
        chk("reset_delays", pack_dly(Delays), 0);
        chk("reset_wrready", int'(WrReady), 1);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_applied", int'(Applied), 0);
        Rst = 1'b0;
        tick(1);

        // Basic commit: ch2=5, quiet channels, apply at k+17.
        WrValid = 1'b1; WrChan = 2'd2; WrDelay = 4'd5;
        tick(1);
        WrValid = 1'b0; Commit = 1'b1; k = cyc + 1;
        model[2] = 4'd5; push_apply(k + DRAIN + 1, 1'b0);
        tick(1);
        Commit = 1'b0;
        chk("busy_after_commit", int'(Busy), 1);
        chk("wrready_in_drain", int'(WrReady), 0);
        tick(DRAIN - 2);
        chk("d2_before_apply", int'(Delays[2]), 0);
        wait_idle("basic", 100);
        chk("d2_after_apply", int'(Delays[2]), 5);

        // One activity pulse at k+8 pushes the apply to k+25.
        WrValid = 1'b1; WrChan = 2'd0; WrDelay = 4'd6;
        tick(1);
        WrValid = 1'b0; Commit = 1'b1; k = cyc + 1;
        model[0] = 4'd6; push_apply(k + 8 + DRAIN + 1, 1'b0);
        tick(1);
        Commit = 1'b0;
        tick(7); Channels = 4'b0001;
        tick(1); Channels = '0;
        wait_idle("activity1", 100);

        // Pulses at k+8 and k+20 push the apply to k+37.
        WrValid = 1'b1; WrChan = 2'd0; WrDelay = 4'd2;
        tick(1);
        WrValid = 1'b0; Commit = 1'b1; k = cyc + 1;
        model[0] = 4'd2; push_apply(k + 20 + DRAIN + 1, 1'b0);
        tick(1);
        Commit = 1'b0;
        tick(7); Channels = 4'b0001;
        tick(1); Channels = '0;
        tick(11); Channels = 4'b0100;
        tick(1); Channels = '0;
        wait_idle("activity2", 100);

        // Writes while busy are refused and never reach Delays.
        Commit = 1'b1; k = cyc + 1;
        push_apply(k + DRAIN + 1, 1'b0);
        tick(1);
        Commit = 1'b0;
        WrValid = 1'b1; WrChan = 2'd1; WrDelay = 4'd3;
        chk("wrready_blocked", int'(WrReady), 0);
        tick(2);
        WrValid = 1'b0;
        wait_idle("blocked", 100);
        chk("d1_unchanged", int'(Delays[1]), 0);

        // Write and commit in the same cycle: the write is included.
        WrValid = 1'b1; WrChan = 2'd3; WrDelay = 4'd9; Commit = 1'b1; k = cyc + 1;
        model[3] = 4'd9; push_apply(k + DRAIN + 1, 1'b0);
        tick(1);
        WrValid = 1'b0; Commit = 1'b0;
        wait_idle("same_cycle", 100);
        chk("d3_after_apply", int'(Delays[3]), 9);

        // Reset at k+5 aborts an in-flight commit and clears everything.
        WrValid = 1'b1; WrChan = 2'd1; WrDelay = 4'd4;
        tick(1);
        WrValid = 1'b0; Commit = 1'b1; k = cyc + 1;
        tick(1);
        Commit = 1'b0;
        tick(4); Rst = 1'b1;
        tick(1); Rst = 1'b0;
        for (int i = 0; i < NCHAN; i++) model[i] = '0;
        chk("midreset_busy", int'(Busy), 0);
        chk("midreset_wrready", int'(WrReady), 1);
        chk("midreset_delays", pack_dly(Delays), 0);
        tick(DRAIN + 4);

        // Commit with nothing staged still drains and applies (all zero after reset).
        Commit = 1'b1; k = cyc + 1;
        push_apply(k + DRAIN + 1, 1'b0);
        tick(1);
        Commit = 1'b0;
        wait_idle("empty_commit", 100);

`ifdef DLYCFG_SWEEP_EN
        // Sweep ch1 from a live value of 7; SweepStart beats a simultaneous Commit.
        WrValid = 1'b1; WrChan = 2'd1; WrDelay = 4'd7; Commit = 1'b1; k = cyc + 1;
        model[1] = 4'd7; push_apply(k + DRAIN + 1, 1'b0);
        tick(1);
        WrValid = 1'b0; Commit = 1'b0;
        wait_idle("pre_sweep", 100);

        SweepStart = 1'b1; SweepChan = 2'd1; Commit = 1'b1; k = cyc + 1;
        for (int v = 0; v < 16; v++) begin
            model[1] = 4'(v);
            push_apply(k + DRAIN + 1 + v * STEP_P, 1'b0);
            step_q.push_back(k + DRAIN + 1 + v * STEP_P + DWELL + 1);
        end
        model[1] = 4'd7;
        push_apply(k + DRAIN + 1 + 16 * STEP_P, 1'b1);
        tick(1);
        SweepStart = 1'b0; Commit = 1'b0;
        tick(30);
        chk("sweep_busy", int'(Busy), 1);
        chk("sweep_wrready", int'(WrReady), 0);
        Commit = 1'b1; WrValid = 1'b1; WrChan = 2'd2; WrDelay = 4'd1;
        tick(1);
        Commit = 1'b0; WrValid = 1'b0;
        wait_idle("sweep", 800);
        chk("sweep_restored", int'(Delays[1]), 7);
        chk("steps_consumed", step_q.size(), 0);
`endif

        tick(4);
        chk("applies_consumed", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
